// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo up/down counter.
// Holds the decoded per-cycle command and parameter sanity checks.
package counter_pkg;

    typedef enum logic [1:0] {
        CMD_HOLD,
        CMD_CLEAR,
        CMD_LOAD,
        CMD_STEP
    } cmd_e;

    // Legal when 1 <= MAX_VAL <= 2**WIDTH-1 and 1 <= STEP <= MAX_VAL.
    function automatic bit params_ok(
        input int width,
        input int max_val,
        input int step,
        input int saturate
    );
        longint top;
        bit     ok;
        ok = 1'b1;
        if (width < 1 || width > 31) begin
            ok = 1'b0;
        end else begin
            top = (longint'(1) << width) - 1;
            if (max_val < 1 || longint'(max_val) > top) ok = 1'b0;
            if (step < 1 || step > max_val) ok = 1'b0;
            if (saturate != 0 && saturate != 1) ok = 1'b0;
        end
        return ok;
    endfunction

    // Priority: clear > load > enable > hold (reset handled in the register).
    function automatic cmd_e decode_cmd(
        input logic clear,
        input logic load,
        input logic enable
    );
        cmd_e c;
        priority case (1'b1)
            clear:   c = CMD_CLEAR;
            load:    c = CMD_LOAD;
            enable:  c = CMD_STEP;
            default: c = CMD_HOLD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mod_step_calc.sv
// Combinational wrap/saturate step arithmetic for mod_counter.
// Works one bit wider than the count so nothing truncates mid-way.
module mod_step_calc
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = (2 ** WIDTH) - 1,
    parameter int STEP     = 1,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             up_dn_i,
    output logic [WIDTH-1:0] next_step_val_o,
    output logic             step_limit_o
);

    localparam logic [WIDTH:0]   MAX_W  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   STEP_W = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   MOD_W  = MAX_W + (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH-1:0] up_wrap;
    logic [WIDTH-1:0] dn_sub;
    logic [WIDTH-1:0] dn_wrap;
    logic             up_over;
    logic             dn_under;

    assign cnt_ext  = {1'b0, count_i};
    assign up_sum   = cnt_ext + STEP_W;
    assign up_over  = up_sum > MAX_W;
    assign up_wrap  = WIDTH'(up_sum - MOD_W);
    assign dn_under = cnt_ext < STEP_W;
    assign dn_sub   = count_i - STEP_V;
    assign dn_wrap  = WIDTH'(cnt_ext + MOD_W - STEP_W);

    // Pick the in-range, wrapped or clamped result for this direction.
    always_comb begin
        next_step_val_o = count_i;
        step_limit_o    = 1'b0;
        if (up_dn_i) begin
            if (up_over) begin
                step_limit_o = 1'b1;
                if (SATURATE != 0) begin
                    next_step_val_o = MAX_V;
                end else begin
                    next_step_val_o = up_wrap;
                end
            end else begin
                next_step_val_o = up_sum[WIDTH-1:0];
            end
        end else begin
            if (dn_under) begin
                step_limit_o = 1'b1;
                if (SATURATE != 0) begin
                    next_step_val_o = '0;
                end else begin
                    next_step_val_o = dn_wrap;
                end
            end else begin
                next_step_val_o = dn_sub;
            end
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulo up/down counter with load, clear and limit events.
// Wrap or clamp at the range ends; limit pulses, ovf_sticky latches it.
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = (2 ** WIDTH) - 1,
    parameter int STEP     = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             limit,
    output logic             ovf_sticky
);

    if (!params_ok(WIDTH, MAX_VAL, STEP, SATURATE)) begin : g_bad_params
        $error("mod_counter: illegal WIDTH/MAX_VAL/STEP/SATURATE");
    end

    localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             limit_q;
    logic             limit_d;
    logic             sticky_q;
    logic             sticky_d;

    cmd_e             cmd;
    logic [WIDTH-1:0] step_val;
    logic             step_lim;
    logic [WIDTH-1:0] load_clip;

    mod_step_calc #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .STEP     (STEP),
        .SATURATE (SATURATE)
    ) u_step (
        .count_i         (count_q),
        .up_dn_i         (up_dn),
        .next_step_val_o (step_val),
        .step_limit_o    (step_lim)
    );

    assign load_clip = ({1'b0, load_val} > MAX_W) ? MAX_V : load_val;

    // Resolve the single command that acts this cycle.
    always_comb begin
        cmd = decode_cmd(clear, load, enable);
    end

    // Next count and limit from the decoded command; sticky absorbs limit.
    always_comb begin
        count_d = count_q;
        limit_d = 1'b0;
        unique case (cmd)
            CMD_CLEAR: begin
                count_d = '0;
            end
            CMD_LOAD: begin
                count_d = load_clip;
            end
            CMD_STEP: begin
                count_d = step_val;
                limit_d = step_lim;
            end
            default: begin
                count_d = count_q;
            end
        endcase
        sticky_d = (sticky_q & ~ovf_clr) | limit_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            limit_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            limit_q  <= limit_d;
            sticky_q <= sticky_d;
        end
    end

    assign count      = count_q;
    assign limit      = limit_q;
    assign ovf_sticky = sticky_q;
    assign at_max     = count_q == MAX_V;
    assign at_min     = count_q == '0;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: four configurations share one stimulus stream.
// An integer model predicts every output each cycle; directed cases pin it.
module tb_mod_counter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       up_dn;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic       ovf_clr;

    logic [3:0] cnt_w  [N];
    logic       amax_w [N];
    logic       amin_w [N];
    logic       lim_w  [N];
    logic       stk_w  [N];

    int m_cnt [N];
    bit m_lim [N];
    bit m_stk [N];
    bit model_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic int cfg_max(input int i);
        case (i)
            0: return 9;
            1: return 9;
            2: return 15;
            default: return 15;
        endcase
    endfunction

    function automatic int cfg_step(input int i);
        case (i)
            0: return 1;
            1: return 3;
            2: return 4;
            default: return 1;
        endcase
    endfunction

    function automatic bit cfg_sat(input int i);
        return i == 2;
    endfunction

    mod_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(1), .SATURATE(0)) dut0 (
        .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn),
        .clear(clear), .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
        .count(cnt_w[0]), .at_max(amax_w[0]), .at_min(amin_w[0]),
        .limit(lim_w[0]), .ovf_sticky(stk_w[0])
    );

    mod_counter #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .SATURATE(0)) dut1 (
        .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn),
        .clear(clear), .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
        .count(cnt_w[1]), .at_max(amax_w[1]), .at_min(amin_w[1]),
        .limit(lim_w[1]), .ovf_sticky(stk_w[1])
    );

    mod_counter #(.WIDTH(4), .MAX_VAL(15), .STEP(4), .SATURATE(1)) dut2 (
        .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn),
        .clear(clear), .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
        .count(cnt_w[2]), .at_max(amax_w[2]), .at_min(amin_w[2]),
        .limit(lim_w[2]), .ovf_sticky(stk_w[2])
    );

    mod_counter #(.WIDTH(4)) dut3 (
        .clk(clk), .rst(rst), .enable(enable), .up_dn(up_dn),
        .clear(clear), .load(load), .load_val(load_val), .ovf_clr(ovf_clr),
        .count(cnt_w[3]), .at_max(amax_w[3]), .at_min(amin_w[3]),
        .limit(lim_w[3]), .ovf_sticky(stk_w[3])
    );

    function automatic void check(input string name,
                                  input logic [31:0] got,
                                  input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, got, exp, $time);
        end
    endfunction

    // Reference model: integer arithmetic straight from the counting rules.
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            int mx;
            int st;
            int nxt;
            bit l;
            mx = cfg_max(i);
            st = cfg_step(i);
            l  = 1'b0;
            nxt = m_cnt[i];
            if (rst) begin
                m_cnt[i] = 0;
                m_lim[i] = 1'b0;
                m_stk[i] = 1'b0;
            end else begin
                if (clear) begin
                    nxt = 0;
                end else if (load) begin
                    nxt = (int'(load_val) > mx) ? mx : int'(load_val);
                end else if (enable) begin
                    if (up_dn) begin
                        if (m_cnt[i] + st > mx) begin
                            l = 1'b1;
                            nxt = cfg_sat(i) ? mx : m_cnt[i] + st - (mx + 1);
                        end else begin
                            nxt = m_cnt[i] + st;
                        end
                    end else begin
                        if (m_cnt[i] < st) begin
                            l = 1'b1;
                            nxt = cfg_sat(i) ? 0 : m_cnt[i] - st + (mx + 1);
                        end else begin
                            nxt = m_cnt[i] - st;
                        end
                    end
                end
                m_cnt[i] = nxt;
                m_lim[i] = l;
                m_stk[i] = (m_stk[i] & ~ovf_clr) | l;
            end
        end
        if (rst) model_valid = 1'b1;
    end

    // Every-cycle comparison of all instances against the model.
    always @(negedge clk) begin
        if (model_valid) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("m%0d.count", i), 32'(cnt_w[i]), m_cnt[i]);
                check($sformatf("m%0d.limit", i), 32'(lim_w[i]), 32'(m_lim[i]));
                check($sformatf("m%0d.sticky", i), 32'(stk_w[i]), 32'(m_stk[i]));
                check($sformatf("m%0d.at_max", i), 32'(amax_w[i]),
                      32'(m_cnt[i] == cfg_max(i)));
                check($sformatf("m%0d.at_min", i), 32'(amin_w[i]),
                      32'(m_cnt[i] == 0));
            end
        end
    end

    task automatic drive(input bit r, input bit c, input bit l,
                         input int lv, input bit e, input bit u,
                         input bit oc);
        rst      = r;
        clear    = c;
        load     = l;
        load_val = 4'(lv);
        enable   = e;
        up_dn    = u;
        ovf_clr  = oc;
        @(posedge clk);
        #2;
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        check("rst.count", 32'(cnt_w[0]), 0);
        check("rst.limit", 32'(lim_w[0]), 0);
        check("rst.sticky", 32'(stk_w[0]), 0);
        check("rst.at_min", 32'(amin_w[0]), 1);
        check("rst.at_max", 32'(amax_w[0]), 0);

        for (int k = 1; k <= 10; k++) begin
            drive(0, 0, 0, 0, 1, 1, 0);
            check($sformatf("decade.count%0d", k), 32'(cnt_w[0]), k % 10);
            check($sformatf("decade.limit%0d", k), 32'(lim_w[0]),
                  32'(k == 10));
            if (k == 9) check("decade.at_max", 32'(amax_w[0]), 1);
        end
        check("decade.sticky", 32'(stk_w[0]), 1);
        check("hex.count10", 32'(cnt_w[3]), 10);

        drive(0, 0, 1, 1, 0, 0, 0);
        check("dnwrap.load", 32'(cnt_w[1]), 1);
        drive(0, 0, 0, 0, 1, 0, 0);
        check("dnwrap.count", 32'(cnt_w[1]), 8);
        check("dnwrap.limit", 32'(lim_w[1]), 1);
        drive(0, 0, 0, 0, 1, 0, 0);
        check("dnwrap.count2", 32'(cnt_w[1]), 5);
        check("dnwrap.limit2", 32'(lim_w[1]), 0);

        drive(0, 0, 1, 14, 0, 0, 0);
        check("sat.load", 32'(cnt_w[2]), 14);
        drive(0, 0, 0, 0, 1, 1, 0);
        check("sat.up1", 32'(cnt_w[2]), 15);
        check("sat.lim1", 32'(lim_w[2]), 1);
        drive(0, 0, 0, 0, 1, 1, 0);
        check("sat.up2", 32'(cnt_w[2]), 15);
        check("sat.lim2", 32'(lim_w[2]), 1);
        check("sat.at_max", 32'(amax_w[2]), 1);
        drive(0, 0, 1, 2, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        check("sat.down", 32'(cnt_w[2]), 0);
        check("sat.limdn", 32'(lim_w[2]), 1);

        drive(0, 1, 1, 7, 1, 1, 0);
        check("prio.clear", 32'(cnt_w[0]), 0);
        check("prio.clear2", 32'(cnt_w[2]), 0);
        drive(0, 0, 1, 12, 0, 0, 0);
        check("prio.clip", 32'(cnt_w[0]), 9);
        check("prio.noclip", 32'(cnt_w[2]), 12);

        drive(0, 0, 0, 0, 0, 0, 1);
        check("sticky.clr", 32'(stk_w[0]), 0);
        drive(0, 0, 0, 0, 1, 1, 1);
        check("sticky.wrap", 32'(cnt_w[0]), 0);
        check("sticky.setwins", 32'(stk_w[0]), 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        check("sticky.clr2", 32'(stk_w[0]), 0);
        check("sticky.nolim", 32'(lim_w[0]), 0);

        drive(0, 0, 1, 9, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 0);
        drive(0, 0, 1, 6, 0, 0, 0);
        check("rstmid.pre", 32'(cnt_w[0]), 6);
        check("rstmid.prestk", 32'(stk_w[0]), 1);
        drive(1, 0, 0, 0, 1, 1, 0);
        check("rstmid.count", 32'(cnt_w[0]), 0);
        check("rstmid.limit", 32'(lim_w[0]), 0);
        check("rstmid.sticky", 32'(stk_w[0]), 0);
        drive(0, 0, 0, 0, 1, 1, 0);
        check("rstmid.first", 32'(cnt_w[0]), 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        check("hold.count", 32'(cnt_w[0]), 1);
        check("hold.limit", 32'(lim_w[0]), 0);

        repeat (3000) begin
            drive($urandom_range(0, 99) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0,
                  1'($urandom),
                  $urandom_range(0, 7) == 0);
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
